fir_mac_sched: RTL and testbench

Time-multiplexed FIR filter controller. It shares one signed Q1.15 multiplier across NUM_TAPS taps and runs one multiply-accumulate per clock over a sample delay line and a programmable coefficient bank. Each accepted input sample produces one filtered output sample. It sits between the audio sample source and the output stage, and owns the multiplier's operand sequencing and coefficient configuration.

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_coef_bank.sv | 38 +++
 rtl/fir_mac_sched.sv | 135 +++++++++++++
 tb/tb_fir_mac_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC controller.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Positive full scale (Q1.15) for tap 0, so a reset filter passes samples through.
  localparam logic [15:0] H0_RESET = 16'h7FFF;

  // Accumulator width. It holds NUM_TAPS rounded (BIT_WIDTH+1)-bit products
  // without overflow.
  function automatic int acc_width(input int bit_width, input int num_taps);
    return bit_width + 1 + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file. Tap 0 resets to positive full scale and all
// other taps reset to zero. Writes are accepted only while the scheduler is
// idle and the address is in range. The read port is combinational and
// indexed by the current tap.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_TAPS  = 8,
  parameter int AW        = $clog2(NUM_TAPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_wr_en,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [BIT_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [BIT_WIDTH-1:0] o_rd_data
);

  logic [NUM_TAPS-1:0][BIT_WIDTH-1:0] r_h;
  logic                               w_commit;

  assign w_commit  = i_we && i_wr_en && (int'(i_wr_addr) < NUM_TAPS);
  assign o_rd_data = r_h[i_rd_addr];

  // Coefficient storage: reset to the pass-through filter, otherwise apply gated writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h    <= '0;
      r_h[0] <= BIT_WIDTH'(H0_RESET);
    end else if (w_commit) begin
      r_h[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/fir_mac_sched.sv
// Time-multiplexed FIR filter. One shared signed multiplier runs one MAC per
// clock over NUM_TAPS taps for each accepted sample.
// The build macro FIR_SAT_EN selects saturating output narrowing. When it is
// not defined, the output is the low BIT_WIDTH bits of the accumulator, which
// wraps in two's complement.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int NUM_TAPS  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BIT_WIDTH-1:0]        sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [BIT_WIDTH-1:0]        coef_wdata,
  output logic [BIT_WIDTH-1:0]        out_sample,
  output logic                        out_valid,
  output logic                        busy
);

  localparam int AW         = $clog2(NUM_TAPS);
  localparam int ACC_WIDTH  = acc_width(BIT_WIDTH, NUM_TAPS);
  localparam int PW         = 2 * BIT_WIDTH;

  state_t                             r_state;
  logic [NUM_TAPS-1:0][BIT_WIDTH-1:0] r_x;
  logic signed [ACC_WIDTH-1:0]        r_acc;
  logic [AW-1:0]                      r_k;
  logic [BIT_WIDTH-1:0]               r_out;
  logic                               r_ov;
  logic                               r_busy;
  logic                               r_ready;

  logic                               w_accept;
  logic [BIT_WIDTH-1:0]               w_x_k;
  logic [BIT_WIDTH-1:0]               w_h_k;
  logic signed [PW-1:0]               w_prod;
  logic signed [BIT_WIDTH:0]          w_rnd;
  logic signed [ACC_WIDTH-1:0]        w_acc_sum;
  logic [BIT_WIDTH-1:0]               w_narrow;
  logic                               w_unused_lsbs;

  assign sample_ready = r_ready;
  assign out_sample   = r_out;
  assign out_valid    = r_ov;
  assign busy         = r_busy;

  // r_ready is high exactly when the FSM is in IDLE, so it doubles as the IDLE qualifier.
  assign w_accept = sample_valid && r_ready;

  fir_coef_bank #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_TAPS  (NUM_TAPS),
    .AW        (AW)
  ) u_coef (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (r_state == IDLE),
    .i_we      (coef_we),
    .i_wr_addr (coef_addr),
    .i_wr_data (coef_wdata),
    .i_rd_addr (r_k),
    .o_rd_data (w_h_k)
  );

  // Shared multiplier. The product is rounded to (W+1) bits by a half-LSB add at bit W-2.
  assign w_x_k         = r_x[r_k];
  assign w_prod        = $signed(w_x_k) * $signed(w_h_k);
  assign w_rnd         = w_prod[PW-1:BIT_WIDTH-1] + {{BIT_WIDTH{1'b0}}, w_prod[BIT_WIDTH-2]};
  assign w_acc_sum     = r_acc + {{(ACC_WIDTH-BIT_WIDTH-1){w_rnd[BIT_WIDTH]}}, w_rnd};
  assign w_unused_lsbs = ^w_prod[BIT_WIDTH-3:0];

  // Narrow the final accumulator value to the output width.
  always_comb begin
    w_narrow = w_acc_sum[BIT_WIDTH-1:0];
`ifdef FIR_SAT_EN
    // The value fits when all bits above the output sign bit are copies of it.
    if (!((&w_acc_sum[ACC_WIDTH-1:BIT_WIDTH-1]) || !(|w_acc_sum[ACC_WIDTH-1:BIT_WIDTH-1])))
      w_narrow = w_acc_sum[ACC_WIDTH-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(BIT_WIDTH-1){1'b1}}};
`endif
  end

  // Sequencing FSM with the delay line, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_out   <= '0;
      r_ov    <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_ov <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x     <= {r_x[NUM_TAPS-2:0], sample_in};
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= MAC;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        MAC: begin
          r_acc <= w_acc_sum;
          r_k   <= r_k + 1'b1;
          if (r_k == AW'(NUM_TAPS - 1)) begin
            r_state <= DONE;
            r_out   <= w_narrow;
            r_ov    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed testbench for fir_mac_sched. The expected values are hand-computed
// Q1.15 results, and the narrowing-dependent cases follow FIR_SAT_EN.
module tb_fir_mac_sched;

  localparam int BW = 16;
  localparam int NT = 8;
  localparam int AW = 3;

`ifdef FIR_SAT_EN
  localparam logic [15:0] EXP_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG = 16'h7FFF;
`else
  localparam logic [15:0] EXP_OVF = 16'hFFFC;
  localparam logic [15:0] EXP_NEG = 16'h8000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [BW-1:0] coef_wdata = '0;
  logic [BW-1:0] out_sample;
  logic          out_valid;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;

  fir_mac_sched #(.BIT_WIDTH(BW), .NUM_TAPS(NT)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .out_sample   (out_sample),
    .out_valid    (out_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0; coef_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr_coef(input logic [AW-1:0] a, input logic [BW-1:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Feed one sample. Return the output value, the number of negedges from
  // acceptance until out_valid, and out_valid one cycle after the pulse.
  task automatic run(input logic [BW-1:0] din, output logic [BW-1:0] dout,
                     output int lat, output logic ov_next);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!sample_ready && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) chk("ready_timeout", 32'(guard), 0);
    sample_in = din; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) chk("out_timeout", 32'(lat), NT);
    dout = out_sample;
    @(negedge clk);
    ov_next = out_valid;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [BW-1:0] d;
    int            lat;
    logic          ovn;
    int            acc_t[$];
    int            bad_mix, dbl, n_ov, guard;
    logic          prev_ov;

    // Reset defaults.
    do_reset();
    chk("rst_ready", sample_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_out", out_sample, 0);

    run(16'h4000, d, lat, ovn);
    chk("pass_out", d, 16'h4000);
    chk("pass_lat", 32'(lat), NT);
    chk("pass_ov_pulse", ovn, 0);
    repeat (3) @(negedge clk);
    chk("pass_hold", out_sample, 16'h4000);

    // Impulse response with all taps at 0x1000.
    do_reset();
    for (int i = 0; i < NT; i++) wr_coef(AW'(i), 16'h1000);
    for (int i = 0; i < NT; i++) begin
      run((i == 0) ? 16'h7FFF : 16'h0000, d, lat, ovn);
      chk($sformatf("imp_%0d", i), d, 16'h1000);
    end
    run(16'h0000, d, lat, ovn);
    chk("imp_tail", d, 16'h0000);

    // Overflow with all taps at positive full scale.
    do_reset();
    for (int i = 0; i < NT; i++) wr_coef(AW'(i), 16'h7FFF);
    run(16'h7FFF, d, lat, ovn);
    chk("ovf_first", d, 16'h7FFE);
    run(16'h7FFF, d, lat, ovn);
    chk("ovf_second", d, EXP_OVF);

    // Negative-one squared.
    do_reset();
    wr_coef(0, 16'h8000);
    run(16'h8000, d, lat, ovn);
    chk("neg_one", d, EXP_NEG);

    // A coefficient write during MAC is ignored.
    do_reset();
    sample_in = 16'h4000; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("mac_ready_low", sample_ready, 0);
    chk("mac_busy", busy, 1);
    coef_we = 1'b1; coef_addr = 0; coef_wdata = 16'h0000;
    @(negedge clk);
    coef_we = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    chk("we_mac_out", out_sample, 16'h4000);
    run(16'h2000, d, lat, ovn);
    chk("we_mac_next", d, 16'h2000);

    // A write in the acceptance cycle is used for that sample.
    do_reset();
    coef_we = 1'b1; coef_addr = 0; coef_wdata = 16'h4000;
    sample_in = 16'h4000; sample_valid = 1'b1;
    @(negedge clk);
    coef_we = 1'b0; sample_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
    chk("we_same_cycle", out_sample, 16'h2000);

    // Continuous sample_valid produces one acceptance every NT+2 cycles.
    do_reset();
    sample_in = 16'h4000; sample_valid = 1'b1;
    bad_mix = 0; dbl = 0; n_ov = 0; prev_ov = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sample_ready) acc_t.push_back(c);
      if (sample_ready == busy) bad_mix++;
      if (out_valid && prev_ov) dbl++;
      if (out_valid) n_ov++;
      prev_ov = out_valid;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("hs_accepts", 32'(acc_t.size()), 4);
    for (int i = 1; i < acc_t.size(); i++)
      chk($sformatf("hs_gap_%0d", i), 32'(acc_t[i] - acc_t[i-1]), NT + 2);
    chk("hs_ready_vs_busy", 32'(bad_mix), 0);
    chk("hs_ov_double", 32'(dbl), 0);
    chk("hs_ov_count", 32'(n_ov), 4);

    // Reset during MAC cycle 3 discards the sample and restores defaults.
    do_reset();
    wr_coef(0, 16'h0000);
    wr_coef(1, 16'h1000);
    @(negedge clk);
    sample_in = 16'h7FFF; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_ov = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) n_ov++;
      @(negedge clk);
    end
    chk("mrst_no_ov", 32'(n_ov), 0);
    chk("mrst_ready", sample_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_out", out_sample, 0);
    run(16'h4000, d, lat, ovn);
    chk("mrst_next", d, 16'h4000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
